// File: rtl/acc_sequencer.sv
// Dot-product sequencer: clears the shared accumulator, issues tap addresses,
// gates accumulation of returning products and holds the sum for handoff.
// Optional macro ACC_SEQ_BIAS_EN adds a signed bias port that seeds the sum.
module acc_sequencer #(
    parameter int BIT   = 8,
    parameter int CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      tap_count,
`ifdef ACC_SEQ_BIAS_EN
    input  logic signed [BIT-1:0] bias,
`endif
    output logic                  busy,
    output logic [CNT_W-1:0]      tap_addr,
    output logic                  tap_valid,
    input  logic                  prod_valid,
    input  logic signed [BIT-1:0] prod_in,
    output logic                  acc_en,
    output logic signed [BIT-1:0] acc_in,
    input  logic signed [BIT-1:0] acc_out,
    output logic signed [BIT-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [2:0]            state_dbg
);

    // Result handshake: result is offered while result_valid=1 and is held
    // unchanged until a cycle with result_valid & result_ready, which retires it.
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SETTLE, DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      n_r;
    logic [CNT_W-1:0]      issued;
    logic [CNT_W-1:0]      received;
    logic signed [BIT-1:0] clear_base;
    logic                  accept;

`ifdef ACC_SEQ_BIAS_EN
    logic signed [BIT-1:0] bias_r;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bias_r <= '0;
        end else if (state == IDLE && start) begin
            bias_r <= bias;
        end
    end

    assign clear_base = bias_r;
`else
    assign clear_base = '0;
`endif

    // rst_n is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state        <= IDLE;
            n_r          <= '0;
            issued       <= '0;
            received     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_r      <= tap_count;
                        issued   <= '0;
                        received <= '0;
                    end
                end
                ACCUM: begin
                    if (tap_valid) issued <= issued + 1'b1;
                    if (accept) received <= received + 1'b1;
                end
                SETTLE: begin
                    result       <= acc_out;
                    result_valid <= 1'b1;
                end
                DONE: begin
                    if (result_ready) result_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        tap_valid = 1'b0;
        tap_addr  = '0;
        acc_en    = 1'b0;
        acc_in    = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                // acc + (base - acc) lands on base at the next edge, wrap included
                acc_en    = 1'b1;
                acc_in    = clear_base - acc_out;
                state_nxt = (n_r == '0) ? SETTLE : ACCUM;
            end
            ACCUM: begin
                if (issued < n_r) begin
                    tap_valid = 1'b1;
                    tap_addr  = issued;
                end
                if (prod_valid && (received < n_r)) begin
                    accept = 1'b1;
                    acc_en = 1'b1;
                    acc_in = prod_in;
                    if (received == n_r - 1'b1) state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (result_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: an accumulator model closes the datapath loop and
// expected sums come from plain arithmetic over the products each job is given.
`timescale 1ns/1ps
module tb_acc_sequencer;
    localparam int BIT   = 8;
    localparam int CNT_W = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  start = 1'b0;
    logic [CNT_W-1:0]      tap_count = '0;
    logic                  prod_valid = 1'b0;
    logic signed [BIT-1:0] prod_in = '0;
    logic signed [BIT-1:0] bias_v = '0;
    logic                  result_ready = 1'b0;
    logic signed [BIT-1:0] acc_out = '0;
    logic                  busy, tap_valid, acc_en, result_valid;
    logic [CNT_W-1:0]      tap_addr;
    logic signed [BIT-1:0] acc_in, result;
    logic [2:0]            state_dbg;

    logic                  preload_en = 1'b0;
    logic signed [BIT-1:0] preload_val = '0;

    int checks = 0;
    int failures = 0;
    logic [BIT-1:0]        exp_q[$];
    logic signed [BIT-1:0] beats[$];
    bit                    vpat[$];

    acc_sequencer #(.BIT(BIT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .tap_count    (tap_count),
`ifdef ACC_SEQ_BIAS_EN
        .bias         (bias_v),
`endif
        .busy         (busy),
        .tap_addr     (tap_addr),
        .tap_valid    (tap_valid),
        .prod_valid   (prod_valid),
        .prod_in      (prod_in),
        .acc_en       (acc_en),
        .acc_in       (acc_in),
        .acc_out      (acc_out),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // Shared accumulator: no clear input, optional preload to plant stale values
    always @(posedge clk) begin
        if (acc_en) acc_out <= acc_out + acc_in;
        else if (preload_en) acc_out <= preload_val;
    end

    function automatic logic signed [BIT-1:0] bias_eff();
`ifdef ACC_SEQ_BIAS_EN
        return bias_v;
`else
        return '0;
`endif
    endfunction

    task automatic preload(input logic signed [BIT-1:0] v);
        @(negedge clk);
        preload_en  = 1'b1;
        preload_val = v;
        @(negedge clk);
        preload_en  = 1'b0;
    endtask

    // Runs one job: mode 0 returns each product one cycle after its tap,
    // mode 1 uses vpat then random gaps; extra beats follow the Nth product.
    task automatic run_job(input int n, input bit mode, input bit stale,
                           input int extra, input int hold, input bit start_done);
        logic signed [BIT-1:0] tmp, sum;
        int delivered, extras_left, done_cyc, taps_before;
        bit seen, finished, pv, exp_tv, exp_en;
        while (beats.size() < n) begin
            tmp = BIT'($urandom_range(0, 255));
            beats.push_back(tmp);
        end
        sum = bias_eff();
        for (int i = 0; i < n; i++) sum = sum + beats[i];
        exp_q.push_back(sum);

        @(negedge clk);
        start      = 1'b1;
        tap_count  = CNT_W'(n);
        prod_valid = stale;
        prod_in    = BIT'($urandom_range(0, 255));
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
        checks++;
        if (acc_en !== 1'b0) begin failures++; $display("FAIL idle_acc_en got=%0b exp=0", acc_en); end

        @(negedge clk);
        start      = 1'b0;
        prod_valid = stale;
        prod_in    = BIT'($urandom_range(0, 255));
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy got=%0b exp=1", busy); end
        checks++;
        if (acc_en !== 1'b1) begin failures++; $display("FAIL clear_acc_en got=%0b exp=1", acc_en); end
        checks++;
        if (acc_in !== BIT'(bias_eff() - acc_out)) begin
            failures++; $display("FAIL clear_acc_in got=%0d exp=%0d", acc_in, BIT'(bias_eff() - acc_out));
        end
        checks++;
        if (tap_valid !== 1'b0) begin failures++; $display("FAIL clear_tap_valid got=%0b exp=0", tap_valid); end

        delivered = 0; extras_left = extra; done_cyc = 0; seen = 0; finished = 0;
        for (int cyc = 2; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (seen && done_cyc == hold + 1) begin
                result_ready = 1'b0;
                start        = 1'b0;
                prod_valid   = 1'b0;
                #1;
                checks++;
                if (result_valid !== 1'b0) begin failures++; $display("FAIL retire_valid got=%0b exp=0", result_valid); end
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL retire_busy got=%0b exp=0", busy); end
                void'(exp_q.pop_front());
                finished = 1;
            end else begin
                if (!seen && result_valid === 1'b1) begin
                    seen = 1;
                    if (!mode) begin
                        checks++;
                        if (cyc - 1 != ((n == 0) ? 2 : n + 3)) begin
                            failures++; $display("FAIL latency got=%0d exp=%0d", cyc - 1, (n == 0) ? 2 : n + 3);
                        end
                    end
                end
                if (seen) begin
                    checks++;
                    if (result_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%0b exp=1", result_valid); end
                    checks++;
                    if (result !== exp_q[0]) begin failures++; $display("FAIL result got=%0d exp=%0d", result, $signed(exp_q[0])); end
                    checks++;
                    if (busy !== 1'b1) begin failures++; $display("FAIL done_busy got=%0b exp=1", busy); end
                    result_ready = (done_cyc == hold);
                    start        = start_done && (done_cyc == 1 || done_cyc == hold);
                    done_cyc++;
                end
                pv = 0;
                taps_before = (cyc - 2 < 0) ? 0 : ((cyc - 2 > n) ? n : cyc - 2);
                if (delivered < n) begin
                    if (delivered < taps_before) begin
                        if (!mode) pv = 1;
                        else if (vpat.size() > 0) pv = vpat.pop_front();
                        else pv = 1'($urandom_range(0, 1));
                    end
                end else if (extras_left > 0) begin
                    pv = 1;
                    extras_left--;
                end
                prod_valid = pv;
                prod_in    = (pv && delivered < n) ? beats[delivered] : BIT'($urandom_range(0, 255));
                #1;
                exp_tv = (cyc - 2 >= 0) && (cyc - 2 < n);
                checks++;
                if (tap_valid !== exp_tv) begin failures++; $display("FAIL tap_valid cyc=%0d got=%0b exp=%0b", cyc, tap_valid, exp_tv); end
                if (exp_tv) begin
                    checks++;
                    if (tap_addr !== CNT_W'(cyc - 2)) begin
                        failures++; $display("FAIL tap_addr got=%0d exp=%0d", tap_addr, cyc - 2);
                    end
                end
                exp_en = pv && (delivered < n);
                checks++;
                if (acc_en !== exp_en) begin failures++; $display("FAIL acc_en cyc=%0d got=%0b exp=%0b", cyc, acc_en, exp_en); end
                if (exp_en) begin
                    checks++;
                    if (acc_in !== beats[delivered]) begin
                        failures++; $display("FAIL acc_in got=%0d exp=%0d", acc_in, beats[delivered]);
                    end
                    delivered++;
                end
            end
        end
        if (!finished) begin
            failures++;
            $display("FAIL job_timeout n=%0d got=no_retire exp=retire", n);
            @(negedge clk);
            rst_n = 1'b1;
            result_ready = 1'b0; start = 1'b0; prod_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        beats.delete();
        vpat.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++;
        if (tap_valid !== 1'b0) begin failures++; $display("FAIL rst_tap_valid got=%0b exp=0", tap_valid); end
        checks++;
        if (acc_en !== 1'b0) begin failures++; $display("FAIL rst_acc_en got=%0b exp=0", acc_en); end
        checks++;
        if (result_valid !== 1'b0) begin failures++; $display("FAIL rst_result_valid got=%0b exp=0", result_valid); end
        checks++;
        if (tap_addr !== '0) begin failures++; $display("FAIL rst_tap_addr got=%0d exp=0", tap_addr); end
        checks++;
        if (result !== '0) begin failures++; $display("FAIL rst_result got=%0d exp=0", result); end
        checks++;
        if (acc_in !== '0) begin failures++; $display("FAIL rst_acc_in got=%0d exp=0", acc_in); end
        rst_n = 1'b0;
    endtask

    task automatic test_basic();
        preload(8'sd37);
        bias_v = '0;
        beats.push_back(8'sd5);
        beats.push_back(-8'sd2);
        beats.push_back(8'sd10);
        run_job(3, 1'b0, 1'b0, 0, 4, 1'b0);
    endtask

    task automatic test_zero_taps();
        bias_v = -8'sd4;
        run_job(0, 1'b0, 1'b1, 1, 2, 1'b0);
        bias_v = '0;
    endtask

    task automatic test_wrap();
        preload(-8'sd128);
        bias_v = '0;
        beats.push_back(8'sd100);
        beats.push_back(8'sd100);
        run_job(2, 1'b0, 1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_gapped();
        bias_v = 8'sd3;
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_job(4, 1'b1, 1'b1, 2, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job(3, 1'b0, 1'b0, 0, 5, 1'b1);
        run_job(2, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        preload(8'sd55);
        @(negedge clk);
        start = 1'b1;
        tap_count = CNT_W'(5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        prod_valid = 1'b1;
        prod_in = 8'sd3;
        @(negedge clk);
        prod_in = 8'sd4;
        @(negedge clk);
        prod_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        checks++;
        if (tap_valid !== 1'b0) begin failures++; $display("FAIL midrst_tap_valid got=%0b exp=0", tap_valid); end
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", result_valid); end
        rst_n = 1'b0;
        bias_v = '0;
        beats.push_back(8'sd7);
        beats.push_back(8'sd8);
        run_job(2, 1'b0, 1'b1, 0, 1, 1'b0);
    endtask

    task automatic test_max_taps();
        bias_v = BIT'($urandom_range(0, 255));
        run_job(31, 1'b1, 1'b0, 1, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            bias_v = BIT'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) preload(BIT'($urandom_range(0, 255)));
            run_job($urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_taps();
        test_wrap();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        test_max_taps();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
